// File: rtl/mmcm_lock_supervisor.sv
// mmcm_lock_supervisor
//
// Brings up an MMCM from its free-running reference clock and keeps it locked.
// It pulses the MMCM reset and waits for LOCKED. It then requires the lock to
// stay stable for a while before releasing the system reset. A lock timeout
// retries the MMCM reset, and a lock loss in RUN re-arms the whole sequence.
//
// Parameters:
//   RST_PULSE_CYCLES    - minimum MMCM_RST high time per pulse (>= 1)
//   LOCK_TIMEOUT_CYCLES - cycles allowed in WAIT_LOCK before a retry (>= 2)
//   STABLE_CYCLES       - consecutive synced-lock cycles before RUN (>= 1)
//   CNT_W               - width of the statistics counters
//
// Ports:
//   CLK           in  reference clock, the same clock that feeds MMCM CLKIN1
//   ASYNC_RESET_N in  asynchronous active-low reset; release is synchronised
//   LOCKED        in  MMCM lock, asynchronous to CLK
//   FORCE_RELOCK  in  synchronous single-cycle request to restart the MMCM
//   MMCM_RST      out drives the MMCM ASYNC_RESET input
//   SYS_RESET_N   out active-low reset for downstream logic
//   READY         out high while in RUN
//   STATE         out 0 RESET_MMCM, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   RETRY_COUNT   out lock timeouts, saturating
//   LOSS_COUNT    out lock losses while in RUN, saturating
//
// Build option:
//   MMCM_SUPERVISOR_STATS_EN - when defined, RETRY_COUNT and LOSS_COUNT are
//   implemented. When undefined, both ports are tied to 0 and the FSM is
//   unchanged.

module mmcm_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             CLK,
  input  logic             ASYNC_RESET_N,
  input  logic             LOCKED,
  input  logic             FORCE_RELOCK,
  output logic             MMCM_RST,
  output logic             SYS_RESET_N,
  output logic             READY,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] RETRY_COUNT,
  output logic [CNT_W-1:0] LOSS_COUNT
);

  // One timer serves as the pulse, timeout and stability counter; every state
  // entry clears it, so it is sized for the longest of the three intervals.
  localparam int unsigned MaxPulseTo = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                       RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles  = (MaxPulseTo > STABLE_CYCLES) ?
                                       MaxPulseTo : STABLE_CYCLES;
  localparam int unsigned TimerW     = $clog2(MaxCycles + 1);

  localparam logic [TimerW-1:0] PulseLast   = TimerW'(RST_PULSE_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerMax    = '1;

  typedef enum logic [1:0] {
    StResetMmcm = 2'd0,
    StWaitLock  = 2'd1,
    StStable    = 2'd2,
    StRun       = 2'd3
  } state_e;

  // Reset: assert immediately, release two edges after ASYNC_RESET_N rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge ASYNC_RESET_N) begin
    if (!ASYNC_RESET_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // LOCKED synchroniser. All FSM decisions use lk.
  logic [1:0] lk_sync_q;
  logic       lk;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      lk_sync_q <= 2'b00;
    end else begin
      lk_sync_q <= {lk_sync_q[0], LOCKED};
    end
  end

  assign lk = lk_sync_q[1];

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q;
  logic              mmcm_rst_q, sys_reset_n_q, ready_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StResetMmcm: begin
        // A lock still visible after the pulse is stale; hold the reset.
        if (timer_q >= PulseLast && !lk) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (FORCE_RELOCK)                 state_d = StResetMmcm;
        else if (lk)                      state_d = StStable;
        else if (timer_q == TimeoutLast)  state_d = StResetMmcm;
      end
      StStable: begin
        if (FORCE_RELOCK)                 state_d = StResetMmcm;
        else if (!lk)                     state_d = StWaitLock;
        else if (timer_q == StableLast)   state_d = StRun;
      end
      StRun: begin
        if (!lk || FORCE_RELOCK)          state_d = StResetMmcm;
      end
      default:                            state_d = StResetMmcm;
    endcase
  end

  // Outputs are computed from the next state so they change on the same edge
  // as the transition.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StResetMmcm;
      timer_q       <= '0;
      mmcm_rst_q    <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != TimerMax) begin
        timer_q <= timer_q + 1'b1;
      end
      mmcm_rst_q    <= (state_d == StResetMmcm);
      sys_reset_n_q <= (state_d == StRun);
      ready_q       <= (state_d == StRun);
    end
  end

  assign MMCM_RST    = mmcm_rst_q;
  assign SYS_RESET_N = sys_reset_n_q;
  assign READY       = ready_q;
  assign STATE       = state_q;

`ifdef MMCM_SUPERVISOR_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] retry_q, loss_q;
  logic             retry_evt, loss_evt;

  // FORCE_RELOCK wins over a timeout, so the only unforced exit from
  // WAIT_LOCK to RESET_MMCM is a timeout. Any lock loss in RUN counts, even
  // alongside FORCE_RELOCK.
  assign retry_evt = (state_q == StWaitLock) && (state_d == StResetMmcm) && !FORCE_RELOCK;
  assign loss_evt  = (state_q == StRun) && !lk;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_evt && retry_q != CntMax) retry_q <= retry_q + 1'b1;
      if (loss_evt && loss_q != CntMax)   loss_q  <= loss_q + 1'b1;
    end
  end

  assign RETRY_COUNT = retry_q;
  assign LOSS_COUNT  = loss_q;
`else
  assign RETRY_COUNT = '0;
  assign LOSS_COUNT  = '0;
`endif

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// Bench for mmcm_lock_supervisor. Expected timings come from the lock/reset
// rules as edge arithmetic; expected statistics come from event tallies
// saturated at 2^CNT_W-1 (or 0 when statistics are compiled out).

module tb_mmcm_lock_supervisor;

  localparam int RstPulse = 8;
  localparam int Timeout  = 32;
  localparam int Stable   = 16;
  localparam int CntW     = 2;
  localparam int RelEdges = 2;  // reset release synchroniser
  localparam int LkEdges  = 3;  // two sync flops plus the FSM edge

`ifdef MMCM_SUPERVISOR_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic            clk;
  logic            async_reset_n;
  logic            locked;
  logic            force_relock;
  logic            mmcm_rst;
  logic            sys_reset_n;
  logic            ready;
  logic [1:0]      state;
  logic [CntW-1:0] retry_count;
  logic [CntW-1:0] loss_count;

  int total  = 0;
  int passed = 0;
  int n_timeouts = 0;
  int n_losses   = 0;

  mmcm_lock_supervisor #(
    .RST_PULSE_CYCLES    (RstPulse),
    .LOCK_TIMEOUT_CYCLES (Timeout),
    .STABLE_CYCLES       (Stable),
    .CNT_W               (CntW)
  ) dut (
    .CLK           (clk),
    .ASYNC_RESET_N (async_reset_n),
    .LOCKED        (locked),
    .FORCE_RELOCK  (force_relock),
    .MMCM_RST      (mmcm_rst),
    .SYS_RESET_N   (sys_reset_n),
    .READY         (ready),
    .STATE         (state),
    .RETRY_COUNT   (retry_count),
    .LOSS_COUNT    (loss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [CntW-1:0] exp_cnt(input int events);
    int sat;
    sat = (1 << CntW) - 1;
    if (!StatsEn) return '0;
    return CntW'((events > sat) ? sat : events);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until STATE first equals st, or -1 when the budget runs out.
  task automatic wait_state(input logic [1:0] st, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (state === st) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic relock(input string tag);
    int n;
    locked = 1'b1;
    wait_state(2'd2, 10, n);
    total++;
    if (n != LkEdges) $display("FAIL %s_stable_edge: got %0d want %0d", tag, n, LkEdges);
    else passed++;
    total++;
    if (sys_reset_n !== 1'b0) $display("FAIL %s_stable_sysrst: got %b want 0", tag, sys_reset_n);
    else passed++;
    wait_state(2'd3, Stable + 5, n);
    total++;
    if (n != Stable) $display("FAIL %s_run_edge: got %0d want %0d", tag, n, Stable);
    else passed++;
    total++;
    if (sys_reset_n !== 1'b1 || ready !== 1'b1 || mmcm_rst !== 1'b0)
      $display("FAIL %s_run_outputs: got sys_reset_n=%b ready=%b mmcm_rst=%b want 1 1 0",
               tag, sys_reset_n, ready, mmcm_rst);
    else passed++;
  endtask

  task automatic test_reset();
    async_reset_n = 1'b0;
    locked        = 1'b0;
    force_relock  = 1'b0;
    repeat (3) tick();
    total++;
    if (mmcm_rst !== 1'b1) $display("FAIL reset_mmcm_rst: got %b want 1", mmcm_rst);
    else passed++;
    total++;
    if (sys_reset_n !== 1'b0 || ready !== 1'b0)
      $display("FAIL reset_sys: got sys_reset_n=%b ready=%b want 0 0", sys_reset_n, ready);
    else passed++;
    total++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state);
    else passed++;
    total++;
    if (retry_count !== '0 || loss_count !== '0)
      $display("FAIL reset_counts: got retry=%0d loss=%0d want 0 0", retry_count, loss_count);
    else passed++;
  endtask

  task automatic test_bringup();
    int n;
    async_reset_n = 1'b1;
    wait_state(2'd1, 40, n);
    total++;
    if (n != RelEdges + RstPulse)
      $display("FAIL bringup_pulse_end: got %0d want %0d", n, RelEdges + RstPulse);
    else passed++;
    total++;
    if (mmcm_rst !== 1'b0) $display("FAIL bringup_mmcm_rst_low: got %b want 0", mmcm_rst);
    else passed++;
    repeat ($urandom_range(2, 12)) tick();
    relock("bringup");
  endtask

  task automatic test_lock_loss();
    int n;
    repeat ($urandom_range(1, 6)) tick();
    locked = 1'b0;
    n_losses++;
    wait_state(2'd0, 10, n);
    total++;
    if (n != LkEdges) $display("FAIL loss_edge: got %0d want %0d", n, LkEdges);
    else passed++;
    total++;
    if (sys_reset_n !== 1'b0 || ready !== 1'b0 || mmcm_rst !== 1'b1)
      $display("FAIL loss_outputs: got sys_reset_n=%b ready=%b mmcm_rst=%b want 0 0 1",
               sys_reset_n, ready, mmcm_rst);
    else passed++;
    total++;
    if (loss_count !== exp_cnt(n_losses) || retry_count !== exp_cnt(n_timeouts))
      $display("FAIL loss_counts: got loss=%0d retry=%0d want %0d %0d",
               loss_count, retry_count, exp_cnt(n_losses), exp_cnt(n_timeouts));
    else passed++;
    wait_state(2'd1, RstPulse + 5, n);
    total++;
    if (n != RstPulse) $display("FAIL loss_pulse: got %0d want %0d", n, RstPulse);
    else passed++;
    relock("loss_resequence");
  endtask

  // Starts in RUN with LOCKED high; the lock stays high into RESET_MMCM.
  task automatic test_force_stale();
    int n;
    int h;
    repeat ($urandom_range(1, 6)) tick();
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    total++;
    if (state !== 2'd0 || mmcm_rst !== 1'b1 || ready !== 1'b0)
      $display("FAIL force_run: got state=%0d mmcm_rst=%b ready=%b want 0 1 0",
               state, mmcm_rst, ready);
    else passed++;
    total++;
    if (loss_count !== exp_cnt(n_losses))
      $display("FAIL force_run_loss: got %0d want %0d", loss_count, exp_cnt(n_losses));
    else passed++;
    h = $urandom_range(RstPulse + 2, RstPulse + 12);
    repeat (h - 1) tick();
    total++;
    if (state !== 2'd0 || mmcm_rst !== 1'b1)
      $display("FAIL stale_hold: got state=%0d mmcm_rst=%b want 0 1", state, mmcm_rst);
    else passed++;
    locked = 1'b0;
    wait_state(2'd1, 10, n);
    total++;
    if (n != LkEdges) $display("FAIL stale_release: got %0d want %0d", n, LkEdges);
    else passed++;
  endtask

  // Starts at WAIT_LOCK entry with LOCKED low.
  task automatic test_timeout(input int count);
    int n;
    for (int i = 0; i < count; i++) begin
      wait_state(2'd0, Timeout + 5, n);
      n_timeouts++;
      total++;
      if (n != Timeout) $display("FAIL timeout_edge: got %0d want %0d", n, Timeout);
      else passed++;
      total++;
      if (retry_count !== exp_cnt(n_timeouts))
        $display("FAIL timeout_retry: got %0d want %0d", retry_count, exp_cnt(n_timeouts));
      else passed++;
      wait_state(2'd1, RstPulse + 5, n);
      total++;
      if (n != RstPulse) $display("FAIL timeout_pulse: got %0d want %0d", n, RstPulse);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    int n;
    int g;
    g = $urandom_range(4, 12);
    locked = 1'b1;
    wait_state(2'd2, 10, n);
    total++;
    if (n != LkEdges) $display("FAIL glitch_stable: got %0d want %0d", n, LkEdges);
    else passed++;
    repeat (g - LkEdges) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_state(2'd1, 10, n);
    total++;
    if (n != 2) $display("FAIL glitch_wait_lock: got %0d want 2", n);
    else passed++;
    wait_state(2'd2, 10, n);
    total++;
    if (n != 1) $display("FAIL glitch_restable: got %0d want 1", n);
    else passed++;
    wait_state(2'd3, Stable + 5, n);
    total++;
    if (n != Stable) $display("FAIL glitch_run: got %0d want %0d", n, Stable);
    else passed++;
    total++;
    if (retry_count !== exp_cnt(n_timeouts) || ready !== 1'b1)
      $display("FAIL glitch_retry: got retry=%0d ready=%b want %0d 1",
               retry_count, ready, exp_cnt(n_timeouts));
    else passed++;
  endtask

  // Starts in RUN; lock loss and FORCE_RELOCK reach the FSM on the same edge.
  task automatic test_simultaneous();
    int n;
    locked = 1'b0;
    n_losses++;
    repeat (LkEdges - 1) tick();
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    total++;
    if (state !== 2'd0) $display("FAIL simul_state: got %0d want 0", state);
    else passed++;
    total++;
    if (loss_count !== exp_cnt(n_losses))
      $display("FAIL simul_loss: got %0d want %0d", loss_count, exp_cnt(n_losses));
    else passed++;
    wait_state(2'd1, RstPulse + 5, n);
    total++;
    if (n != RstPulse) $display("FAIL simul_pulse: got %0d want %0d", n, RstPulse);
    else passed++;
  endtask

  // Starts at WAIT_LOCK entry with LOCKED low.
  task automatic test_force_wait();
    int n;
    repeat ($urandom_range(0, 10)) tick();
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    total++;
    if (state !== 2'd0 || retry_count !== exp_cnt(n_timeouts))
      $display("FAIL force_wait: got state=%0d retry=%0d want 0 %0d",
               state, retry_count, exp_cnt(n_timeouts));
    else passed++;
    repeat (2) tick();
    force_relock = 1'b1;  // ignored in RESET_MMCM
    tick();
    force_relock = 1'b0;
    wait_state(2'd1, RstPulse + 5, n);
    total++;
    if (n != RstPulse - 3) $display("FAIL force_ignored: got %0d want %0d", n, RstPulse - 3);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    int iters;
    iters = $urandom_range(2, 4);
    for (int i = 0; i < iters; i++) begin
      relock("b2b");
      repeat ($urandom_range(0, 8)) tick();
      locked = 1'b0;
      n_losses++;
      wait_state(2'd0, 10, n);
      total++;
      if (n != LkEdges || loss_count !== exp_cnt(n_losses))
        $display("FAIL b2b_loss: got edge=%0d loss=%0d want %0d %0d",
                 n, loss_count, LkEdges, exp_cnt(n_losses));
      else passed++;
      wait_state(2'd1, RstPulse + 5, n);
      total++;
      if (n != RstPulse) $display("FAIL b2b_pulse: got %0d want %0d", n, RstPulse);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    int n;
    relock("pre_reset");
    repeat ($urandom_range(1, 5)) tick();
    #3;
    async_reset_n = 1'b0;
    locked        = 1'b0;
    n_timeouts    = 0;
    n_losses      = 0;
    #1;
    total++;
    if (state !== 2'd0 || mmcm_rst !== 1'b1 || sys_reset_n !== 1'b0 || ready !== 1'b0)
      $display("FAIL async_reset_outputs: got state=%0d mmcm_rst=%b sys=%b ready=%b want 0 1 0 0",
               state, mmcm_rst, sys_reset_n, ready);
    else passed++;
    total++;
    if (retry_count !== '0 || loss_count !== '0)
      $display("FAIL async_reset_counts: got retry=%0d loss=%0d want 0 0",
               retry_count, loss_count);
    else passed++;
    repeat (2) tick();
    async_reset_n = 1'b1;
    wait_state(2'd1, 40, n);
    total++;
    if (n != RelEdges + RstPulse)
      $display("FAIL async_rerelease: got %0d want %0d", n, RelEdges + RstPulse);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_force_stale();
    test_timeout(3);
    test_glitch();
    test_simultaneous();
    test_force_wait();
    test_timeout(5);
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmcm_lock_supervisor.md
# mmcm_lock_supervisor

Supervises the MMCM clock generator from its free-running input reference clock. It pulses the MMCM reset and waits for `LOCKED` to assert, then requires lock to stay stable before releasing the system reset. On lock timeout it retries, and on lock loss it re-arms the sequence. It is the control-side counterpart that drives the MMCM's `ASYNC_RESET` and consumes its `LOCKED`.

## Interface
- `RST_PULSE_CYCLES`, 8 — cycles `MMCM_RST` is held high per reset pulse (≥1)
- `LOCK_TIMEOUT_CYCLES`, 65536 — max cycles in WAIT_LOCK before retry (≥2)
- `STABLE_CYCLES`, 1024 — consecutive synced-lock cycles required before RUN (≥1)
- `CNT_W`, 8 — width of statistics counters

- `CLK` in 1 — free-running reference clock, the same one that feeds the MMCM `CLKIN1`
- `ASYNC_RESET_N` in 1 — reset; **asynchronous, active-low**
- `LOCKED` in 1 — MMCM lock; asynchronous to `CLK`
- `FORCE_RELOCK` in 1 — synchronous single-cycle request to restart the MMCM
- `MMCM_RST` out 1 — drives the MMCM `ASYNC_RESET` input
- `SYS_RESET_N` out 1 — active-low system reset for downstream logic; downstream synchronises it into the generated domain
- `READY` out 1 — high while in RUN
- `STATE` out 2 — 0 RESET_MMCM, 1 WAIT_LOCK, 2 STABLE, 3 RUN
- `RETRY_COUNT` out `CNT_W` — lock timeouts, saturating
- `LOSS_COUNT` out `CNT_W` — lock losses while in RUN, saturating

## Operation
- `LOCKED` passes through a 2-flop synchroniser to produce `lk`. All FSM decisions use `lk`.
- **RESET_MMCM:** `MMCM_RST`=1 and a pulse counter runs.
  - Exit to WAIT_LOCK when the counter reaches `RST_PULSE_CYCLES` **and** `lk`=0. This blocks a stale lock from before the reset.
  - If `lk` is still 1 at that point, stay in RESET_MMCM with `MMCM_RST` held.
- **WAIT_LOCK:** `MMCM_RST`=0; the timeout counter increments each cycle.
  - `lk`=1 → STABLE.
  - Counter reaches `LOCK_TIMEOUT_CYCLES`-1 with `lk`=0 → RESET_MMCM and `RETRY_COUNT`+1.
- **STABLE:** the stability counter increments while `lk`=1.
  - `lk`=0 → WAIT_LOCK; the timeout counter restarts from 0 and no count increments.
  - Counter reaches `STABLE_CYCLES`-1 with `lk`=1 → RUN.
- **RUN:** `SYS_RESET_N`=1, `READY`=1.
  - `lk`=0 → RESET_MMCM and `LOSS_COUNT`+1.
- **FORCE_RELOCK:** in WAIT_LOCK, STABLE or RUN it goes to RESET_MMCM with no counter change. It is ignored in RESET_MMCM.
- **Simultaneous events in RUN:** lock loss and `FORCE_RELOCK` together count as a loss (`LOSS_COUNT`+1).
- **Counters:** `RETRY_COUNT` and `LOSS_COUNT` saturate at 2^`CNT_W`-1 and clear only on `ASYNC_RESET_N`.
- Every state entry clears the pulse, timeout and stability counters.

## Timing
- **Reset values:** `MMCM_RST`=1, `SYS_RESET_N`=0, `READY`=0, `STATE`=0, both counts 0, synchroniser flops 0.
- All outputs are registered. `STATE`, `MMCM_RST`, `SYS_RESET_N` and `READY` update on the same edge as the transition.
- **`LOCKED` fall in RUN:** `SYS_RESET_N`/`READY` go low and `MMCM_RST` goes high on the 3rd `CLK` edge after the fall (2 sync + 1 FSM).
- **`LOCKED` rise in WAIT_LOCK:** STABLE is entered on the 3rd edge. RUN is entered `STABLE_CYCLES` edges later if lock holds.
- **MMCM reset pulse:** minimum `MMCM_RST` high time is exactly `RST_PULSE_CYCLES` cycles, counted from the first edge after reset release or state entry.
- **Reset mid-operation:** asserting `ASYNC_RESET_N` low immediately forces all reset values, with no wait for a clock edge. Deassertion is synchronised internally with a 2-flop release.

## Configuration
- `MMCM_SUPERVISOR_STATS_EN` defined: `RETRY_COUNT` and `LOSS_COUNT` are implemented as described.
- Not defined: both ports are tied to 0 and the counter logic is removed. FSM behaviour is identical.

## Test plan
- **Normal bring-up** (`RST_PULSE_CYCLES`=8, `STABLE_CYCLES`=16): release reset, assert `LOCKED` 20 cycles later.
  - `MMCM_RST` is high 8 cycles.
  - RUN is entered 3+16 edges after the `LOCKED` rise.
  - `SYS_RESET_N`=1 and `READY`=1 on that edge.
- **Lock timeout** (`LOCK_TIMEOUT_CYCLES`=32): keep `LOCKED`=0.
  - Return to RESET_MMCM after 32 cycles in WAIT_LOCK.
  - `RETRY_COUNT` increments 1, 2, 3 over three timeouts.
- **Glitchy lock:** `LOCKED` high 10 cycles, low 1, high again (`STABLE_CYCLES`=16).
  - STABLE → WAIT_LOCK → STABLE.
  - RUN is reached only after 16 uninterrupted cycles; `RETRY_COUNT` is unchanged.
- **Lock loss in RUN:** drop `LOCKED`.
  - `SYS_RESET_N` is low on the 3rd edge; `LOSS_COUNT`=1.
  - Full resequence to RUN once `LOCKED` returns.
- **`FORCE_RELOCK` in RUN, then simultaneous with lock loss:**
  - First: RESET_MMCM with `LOSS_COUNT` unchanged.
  - Second: `LOSS_COUNT`+1.
- **Stale lock and saturation** (`CNT_W`=2):
  - Hold `LOCKED`=1 through RESET_MMCM; FSM stays in RESET_MMCM past 8 cycles until `LOCKED` falls.
  - Force 5 timeouts; `RETRY_COUNT` stays at 3.
